adda_sample_sequencer: RTL and testbench

Sequences the ULX3S ADDA add-on converters: generates ADCLK/DACLK at a programmable rate, captures 8-bit ADC samples into a valid-qualified stream and feeds the DAC.
- DAC source is selected per run: ADC loopback, ramp test pattern, buffered external stream, or midscale hold.
- Discards the ADC pipeline-latency samples after each start.
- Sits between the board pins (top level) and sample consumers/producers.

---
 rtl/adda_pkg.sv | 20 ++
 rtl/adda_sample_sequencer_if.sv | 22 ++
 rtl/adda_stream_fifo.sv | 46 ++++
 rtl/adda_sample_sequencer.sv | 159 +++++++++++++++
 tb/tb_adda_sample_sequencer.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/adda_pkg.sv
// Shared types and constants for the ULX3S ADDA converter sequencer.
package adda_pkg;

    localparam int ADDA_DATA_W = 8;
    localparam logic [ADDA_DATA_W-1:0] DAC_MIDSCALE = 8'h80;

    typedef enum logic [1:0] {
        SRC_LOOP   = 2'd0,
        SRC_RAMP   = 2'd1,
        SRC_STREAM = 2'd2,
        SRC_MID    = 2'd3
    } dac_src_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } state_e;

endpackage

// File: rtl/adda_sample_sequencer_if.sv
// Sample streams between the sequencer and its consumers/producers.
// master = sequencer side (accepts the DAC stream, emits captured ADC samples).
interface adda_sample_sequencer_if;
    import adda_pkg::*;

    logic [ADDA_DATA_W-1:0] s_data;
    logic                   s_valid;
    logic                   s_ready;
    logic [ADDA_DATA_W-1:0] m_data;
    logic                   m_valid;

    modport master (
        input  s_data, s_valid,
        output s_ready, m_data, m_valid
    );

    modport slave (
        output s_data, s_valid,
        input  s_ready, m_data, m_valid
    );

endinterface

// File: rtl/adda_stream_fifo.sv
// Small synchronous FIFO buffering the external DAC stream.
module adda_stream_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/adda_sample_sequencer.sv
// Generates ADCLK/DACLK, captures ADC samples after pipeline warm-up and
// drives the DAC from a per-run selectable source.
module adda_sample_sequencer
    import adda_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int ADC_LATENCY = 3,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk_25mhz,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [DIV_W-1:0]       clk_div,
    input  logic [1:0]             dac_src,
    input  logic [ADDA_DATA_W-1:0] adc_data,
    output logic                   adc_clk,
    output logic                   dac_clk,
    output logic [ADDA_DATA_W-1:0] dac_data,
    output logic [15:0]            sample_cnt,
    output logic                   underrun,
    input  logic                   underrun_clr,
    output logic                   busy,
    adda_sample_sequencer_if.master bus
);

    localparam int PW  = DIV_W + 1;
    localparam int WCW = (ADC_LATENCY < 1) ? 1 : $clog2(ADC_LATENCY + 1);
    localparam logic [WCW-1:0] WARM_RELOAD = WCW'(ADC_LATENCY);

    state_e                 state;
    logic [PW-1:0]          phase;
    logic [PW-1:0]          period;
    logic                   adc_clk_q;
    logic [ADDA_DATA_W-1:0] dac_data_q;
    logic [ADDA_DATA_W-1:0] m_data_q;
    logic                   m_valid_q;
    logic [15:0]            sample_cnt_q;
    logic                   underrun_q;
    logic                   loop_valid;
    logic [ADDA_DATA_W-1:0] ramp;
    logic [WCW-1:0]         warm_cnt;

    logic [PW-1:0]          period_req;
    logic [PW-1:0]          phase_nxt;
    logic                   adc_nxt;
    logic                   fall;
    logic                   pop_req;
    dac_src_e               src;

    logic [ADDA_DATA_W-1:0] fifo_head;
    logic                   fifo_full;
    logic                   fifo_empty;

    assign src = dac_src_e'(dac_src);

    // Next-phase and fall-event decode; a new period only takes hold at phase 0.
    always_comb begin
        period_req = (clk_div == '0) ? PW'(2) : ({1'b0, clk_div} + PW'(1));
        phase_nxt  = (phase == period - PW'(1)) ? '0 : phase + PW'(1);
        adc_nxt    = phase_nxt < (period >> 1);
        fall       = (state != IDLE) && enable && adc_clk_q && !adc_nxt;
        pop_req    = fall && (src == SRC_STREAM);
    end

    adda_stream_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ADDA_DATA_W)
    ) u_fifo (
        .clk       (clk_25mhz),
        .rst_n     (rst_n),
        .push      (bus.s_valid),
        .push_data (bus.s_data),
        .pop       (pop_req),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            phase        <= '0;
            period       <= PW'(2);
            adc_clk_q    <= 1'b0;
            dac_data_q   <= DAC_MIDSCALE;
            m_data_q     <= '0;
            m_valid_q    <= 1'b0;
            sample_cnt_q <= '0;
            underrun_q   <= 1'b0;
            loop_valid   <= 1'b0;
            ramp         <= '0;
            warm_cnt     <= WARM_RELOAD;
        end else begin
            m_valid_q <= 1'b0;
            if (underrun_clr)          underrun_q <= 1'b0;
            if (pop_req && fifo_empty) underrun_q <= 1'b1;

            case (state)
                IDLE: begin
                    if (enable) begin
                        state      <= WARMUP;
                        phase      <= '0;
                        period     <= period_req;
                        adc_clk_q  <= 1'b1;
                        loop_valid <= 1'b0;
                    end
                end
                default: begin
                    if (!enable) begin
                        state      <= IDLE;
                        phase      <= '0;
                        adc_clk_q  <= 1'b0;
                        dac_data_q <= DAC_MIDSCALE;
                        ramp       <= '0;
                        warm_cnt   <= WARM_RELOAD;
                    end else begin
                        phase     <= phase_nxt;
                        adc_clk_q <= adc_nxt;
                        if (phase_nxt == '0) period <= period_req;

                        if (fall) begin
                            // Warm-up falls flush the converter pipeline without emitting samples.
                            if (state == WARMUP) begin
                                warm_cnt <= warm_cnt - WCW'(1);
                                if (warm_cnt <= WCW'(1)) state <= RUN;
                            end else begin
                                m_data_q     <= adc_data;
                                m_valid_q    <= 1'b1;
                                sample_cnt_q <= sample_cnt_q + 16'd1;
                                loop_valid   <= 1'b1;
                            end

                            case (src)
                                SRC_LOOP:   dac_data_q <= loop_valid ? m_data_q : DAC_MIDSCALE;
                                SRC_RAMP: begin
                                    dac_data_q <= ramp;
                                    ramp       <= ramp + 8'd1;
                                end
                                SRC_STREAM: if (!fifo_empty) dac_data_q <= fifo_head;
                                default:    dac_data_q <= DAC_MIDSCALE;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign adc_clk     = adc_clk_q;
    assign dac_clk     = adc_clk_q;
    assign dac_data    = dac_data_q;
    assign sample_cnt  = sample_cnt_q;
    assign underrun    = underrun_q;
    assign busy        = (state != IDLE);
    assign bus.s_ready = !fifo_full;
    assign bus.m_data  = m_data_q;
    assign bus.m_valid = m_valid_q;

endmodule

// File: tb/tb_adda_sample_sequencer.sv
// Scoreboard bench for adda_sample_sequencer: directed runs queue expected samples/DAC codes.
module tb_adda_sample_sequencer;
    import adda_pkg::*;

    logic       clk_25mhz = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [7:0] clk_div;
    logic [1:0] dac_src;
    logic [7:0] adc_data;
    logic       adc_clk;
    logic       dac_clk;
    logic [7:0] dac_data;
    logic [15:0] sample_cnt;
    logic       underrun;
    logic       underrun_clr;
    logic       busy;

    int tests_run = 0;
    int tests_failed = 0;

    logic [23:0] m_q [$];
    logic [7:0]  dac_q [$];
    logic [15:0] exp_cnt = 16'd0;
    logic        prev_adc = 1'b0;

    adda_sample_sequencer_if bus ();

    adda_sample_sequencer #(
        .DIV_W       (8),
        .ADC_LATENCY (3),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk_25mhz    (clk_25mhz),
        .rst_n        (rst_n),
        .enable       (enable),
        .clk_div      (clk_div),
        .dac_src      (dac_src),
        .adc_data     (adc_data),
        .adc_clk      (adc_clk),
        .dac_clk      (dac_clk),
        .dac_data     (dac_data),
        .sample_cnt   (sample_cnt),
        .underrun     (underrun),
        .underrun_clr (underrun_clr),
        .busy         (busy),
        .bus          (bus)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic report_fail(input string name);
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL %s: got event, expected none/other at %0t", name, $time);
    endtask

    task automatic apply_stimulus(input logic en, input logic [7:0] div,
                                  input logic [1:0] src, input logic [7:0] adc);
        enable   = en;
        clk_div  = div;
        dac_src  = src;
        adc_data = adc;
    endtask

    task automatic expect_samples(input int n, input logic [7:0] data);
        for (int i = 0; i < n; i++) begin
            exp_cnt = exp_cnt + 16'd1;
            m_q.push_back({data, exp_cnt});
        end
    endtask

    // Returns the number of negedges until the n-th running ADCLK fall is visible.
    task automatic wait_falls(input int n, output int cycles);
        int   seen;
        logic prev;
        seen   = 0;
        cycles = 0;
        prev   = adc_clk;
        while (seen < n && cycles < 4000) begin
            @(negedge clk_25mhz);
            cycles++;
            if (prev && !adc_clk && busy) seen++;
            prev = adc_clk;
        end
        if (seen < n) report_fail("wait_falls_timeout");
    endtask

    // Monitor: samples on m_valid, DAC codes on each running ADCLK fall.
    always @(negedge clk_25mhz) begin
        logic [23:0] em;
        logic [7:0]  ed;
        if (rst_n) begin
            if (bus.m_valid) begin
                if (m_q.size() == 0) begin
                    report_fail("unexpected_m_valid");
                end else begin
                    em = m_q.pop_front();
                    check_output("m_data", bus.m_data, em[23:16]);
                    check_output("sample_cnt", sample_cnt, em[15:0]);
                end
            end
            if (prev_adc && !adc_clk && busy && dac_q.size() > 0) begin
                ed = dac_q.pop_front();
                check_output("dac_data", dac_data, ed);
            end
        end
        prev_adc <= adc_clk;
    end

    initial begin
        #4_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         c;
        logic [7:0] pattern;
        logic [7:0] words [4];
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;

        rst_n        = 1'b0;
        underrun_clr = 1'b0;
        bus.s_data   = 8'h00;
        bus.s_valid  = 1'b0;
        apply_stimulus(1'b0, 8'd3, SRC_MID, 8'h00);
        repeat (3) @(negedge clk_25mhz);

        check_output("rst_adc_clk", adc_clk, 0);
        check_output("rst_dac_clk", dac_clk, 0);
        check_output("rst_dac_data", dac_data, 8'h80);
        check_output("rst_m_data", bus.m_data, 0);
        check_output("rst_m_valid", bus.m_valid, 0);
        check_output("rst_sample_cnt", sample_cnt, 0);
        check_output("rst_underrun", underrun, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_s_ready", bus.s_ready, 1);

        rst_n = 1'b1;
        @(negedge clk_25mhz);

        // Period 4: 2 high / 2 low, first sample on the 4th fall.
        expect_samples(1, 8'hA5);
        apply_stimulus(1'b1, 8'd3, SRC_MID, 8'hA5);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_25mhz);
            pattern[i] = adc_clk;
            if (i == 0) check_output("dac_clk_eq_adc_clk", dac_clk, 1);
        end
        check_output("adc_clk_pattern_p4", pattern, 8'h33);
        wait_falls(2, c);
        check_output("first_sample_cycle", 8 + c, 15);
        enable = 1'b0;
        @(negedge clk_25mhz);
        check_output("idle_busy", busy, 0);

        // Ramp at period 2, including the 0xFF -> 0x00 wrap.
        for (int i = 0; i < 258; i++) dac_q.push_back(8'(i));
        expect_samples(255, 8'h3C);
        apply_stimulus(1'b1, 8'd1, SRC_RAMP, 8'h3C);
        wait_falls(258, c);
        check_output("ramp_run_cycles", c, 516);
        enable = 1'b0;
        @(negedge clk_25mhz);

        // Loopback: midscale until the first sample exists, then one period behind.
        dac_q.push_back(8'h80); dac_q.push_back(8'h80); dac_q.push_back(8'h80);
        dac_q.push_back(8'h80); dac_q.push_back(8'h5A); dac_q.push_back(8'hC3);
        expect_samples(1, 8'h5A);
        expect_samples(2, 8'hC3);
        apply_stimulus(1'b1, 8'd3, SRC_LOOP, 8'h5A);
        wait_falls(4, c);
        adc_data = 8'hC3;
        wait_falls(2, c);
        enable = 1'b0;
        @(negedge clk_25mhz);

        // Stream: fill FIFO while idle, then a rejected push while full.
        for (int i = 0; i < 4; i++) begin
            bus.s_data  = words[i];
            bus.s_valid = 1'b1;
            check_output("s_ready_before_push", bus.s_ready, 1);
            @(negedge clk_25mhz);
        end
        bus.s_data = 8'h55;
        check_output("s_ready_full", bus.s_ready, 0);
        @(negedge clk_25mhz);
        bus.s_valid = 1'b0;
        check_output("s_ready_still_full", bus.s_ready, 0);

        dac_q.push_back(8'h11); dac_q.push_back(8'h22); dac_q.push_back(8'h33);
        dac_q.push_back(8'h44); dac_q.push_back(8'h44);
        expect_samples(2, 8'h77);
        apply_stimulus(1'b1, 8'd1, SRC_STREAM, 8'h77);
        wait_falls(4, c);
        check_output("underrun_before_empty_pop", underrun, 0);
        check_output("s_ready_after_drain", bus.s_ready, 1);
        wait_falls(1, c);
        check_output("underrun_set", underrun, 1);
        enable       = 1'b0;
        underrun_clr = 1'b1;
        @(negedge clk_25mhz);
        check_output("underrun_cleared", underrun, 0);
        check_output("stop_busy", busy, 0);
        check_output("stop_dac_data", dac_data, 8'h80);
        underrun_clr = 1'b0;

        // Set beats clear when both land on the same edge.
        dac_q.push_back(8'h80);
        underrun_clr = 1'b1;
        apply_stimulus(1'b1, 8'd1, SRC_STREAM, 8'h77);
        wait_falls(1, c);
        check_output("underrun_set_wins", underrun, 1);
        @(negedge clk_25mhz);
        check_output("underrun_clr_after", underrun, 0);
        enable       = 1'b0;
        underrun_clr = 1'b0;
        @(negedge clk_25mhz);

        // Drop enable at phase 1 of a period, then re-run the warm-up.
        for (int i = 0; i < 5; i++) dac_q.push_back(8'(i));
        expect_samples(2, 8'h96);
        apply_stimulus(1'b1, 8'd3, SRC_RAMP, 8'h96);
        wait_falls(5, c);
        repeat (3) @(negedge clk_25mhz);
        check_output("adc_clk_before_drop", adc_clk, 1);
        enable = 1'b0;
        @(negedge clk_25mhz);
        check_output("drop_busy", busy, 0);
        check_output("drop_adc_clk", adc_clk, 0);
        check_output("drop_dac_clk", dac_clk, 0);
        check_output("drop_dac_data", dac_data, 8'h80);
        for (int i = 0; i < 4; i++) dac_q.push_back(8'(i));
        expect_samples(1, 8'h96);
        enable = 1'b1;
        wait_falls(4, c);
        check_output("rewarm_first_sample_cycle", c, 15);
        enable = 1'b0;
        @(negedge clk_25mhz);

        // Divider changes apply at period boundaries: 4 -> 8 -> 2.
        expect_samples(2, 8'hE1);
        apply_stimulus(1'b1, 8'd3, SRC_MID, 8'hE1);
        wait_falls(1, c);
        check_output("div3_first_fall", c, 3);
        clk_div = 8'd7;
        wait_falls(1, c);
        check_output("div_change_boundary", c, 6);
        wait_falls(1, c);
        check_output("div7_period", c, 8);
        clk_div = 8'd0;
        wait_falls(1, c);
        check_output("div0_boundary", c, 5);
        wait_falls(1, c);
        check_output("div0_period", c, 2);
        enable = 1'b0;
        repeat (2) @(negedge clk_25mhz);

        check_output("sample_queue_drained", m_q.size(), 0);
        check_output("dac_queue_drained", dac_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
